mul_hilo_ctrl: RTL

MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

---
 rtl/mul_hilo_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequencing controller for a combinational Booth multiplier,
// plus the architectural HI/LO register pair.
//  - Operands are registered onto mul_a/mul_b and held stable while the
//    multiplier settles for WAIT_CYCLES cycles.
//  - On the final settle cycle the 64-bit product {mul_hi, mul_lo} lands in
//    HI/LO, and done pulses for one cycle.
//  - MTHI/MTLO-style direct writes are accepted whenever no multiply is in
//    flight.
// Optional feature: define HILO_BYPASS_EN to forward the product onto
// hi_out/lo_out combinationally during the last settle cycle.
module mul_hilo_ctrl #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        hilo_ld,
  input  logic        hilo_sel,
  input  logic [31:0] hilo_din,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_lo,
  input  logic [31:0] mul_hi,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Counter starts at WAIT_CYCLES-1 so the capture edge is T+WAIT_CYCLES.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mul_hilo_ctrl: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        accept;
  logic        capture;
  logic        load;

  // A new multiply may begin from IDLE or DONE; a flush on the same edge wins.
  assign accept  = (state != ST_SETTLE) && start && !flush;
  assign capture = (state == ST_SETTLE) && !flush && (cnt == 4'd0);
  assign load    = (state != ST_SETTLE) && hilo_ld;

  assign busy = (state == ST_SETTLE);
  assign done = (state == ST_DONE);

  // Sequencer: state, settle counter and the held operand registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      mul_a <= 32'd0;
      mul_b <= 32'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            mul_a <= op_a;
            mul_b <= op_b;
            cnt   <= CNT_INIT;
            state <= ST_SETTLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (flush)              state <= ST_IDLE;
          else if (cnt == 4'd0)   state <= ST_DONE;
          else                    cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // HI/LO: product capture overwrites both halves; a direct write touches one.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (capture) begin
      hi_r <= mul_hi;
      lo_r <= mul_lo;
    end else if (load) begin
      if (hilo_sel) hi_r <= hilo_din;
      else          lo_r <= hilo_din;
    end
  end

`ifdef HILO_BYPASS_EN
  // Forward the settled product a cycle before it is registered.
  assign hi_out = capture ? mul_hi : hi_r;
  assign lo_out = capture ? mul_lo : lo_r;
`else
  assign hi_out = hi_r;
  assign lo_out = lo_r;
`endif

endmodule
